// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Register map on address[3:2]: 0 DATA (W), 1 STATUS (R, W1C overflow on
// bit 3), 2 DIVISOR (R/W), 3 reserved.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit before
// the stop bit and advertises it in STATUS bit 8.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [15:0] address,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic PARITY_CAP = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic PARITY_CAP = 1'b0;
`endif

  // FIFO and register state
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;

  // Transmit FSM state
  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;

  logic [1:0]    reg_sel;
  logic          wr_en, push, push_ok, pop, full, empty;
  logic [15:0]   div_eff, reload;
  logic [7:0]    head;
  logic [31:0]   cnt_ext;
  logic [31:0]   status;
  logic          tx_c;
  logic          unused_bits;

  assign reg_sel = address[3:2];
  assign wr_en   = sel & we;
  assign push    = wr_en && (reg_sel == 2'd0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = (state_q == S_IDLE) && !empty;
  // A pop on the same edge frees the slot the push needs, so a full FIFO
  // still accepts the byte.
  assign push_ok = push && (!full || pop);
  assign head    = fifo_q[rd_ptr_q];
  assign div_eff = (div_q == '0) ? 16'd1 : div_q;
  assign reload  = div_eff - 16'd1;
  assign cnt_ext = 32'(count_q);

  assign unused_bits = ^{address[15:4], address[1:0], wd[31:16]};

  // FIFO bookkeeping and register writes
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && !push_ok) ovf_d = 1'b1;
    if (wr_en && (reg_sel == 2'd1) && wd[3]) ovf_d = 1'b0;
    if (wr_en && (reg_sel == 2'd2)) div_d = wd[15:0];
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= wd[7:0];
  end

  // Register state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
    end
  end

  // Transmit FSM: next state, baud countdown and line level
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_c    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = head;
          par_d   = ^head;
          baud_d  = reload;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_c = 1'b0;
        if (baud_q == '0) begin
          baud_d  = reload;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        tx_c = shift_q[0];
        if (baud_q == '0) begin
          baud_d = reload;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_c = par_q;
        if (baud_q == '0) begin
          baud_d  = reload;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        tx_c = 1'b1;
        if (baud_q == '0) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx      = tx_c;
  assign tx_busy = (state_q != S_IDLE) || !empty;

  assign status = {23'b0, PARITY_CAP, cnt_ext[3:0], ovf_q, empty, full, tx_busy};

  // Combinational read mux, zero outside the selected region
  always_comb begin
    rd = '0;
    if (sel) begin
      case (reg_sel)
        2'd1:    rd = status;
        2'd2:    rd = {16'b0, div_q};
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed checks of mmio_uart_tx against a
// frame-level model (expected per-cycle tx levels built from byte lists).
module tb_mmio_uart_tx;

  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam logic [31:0] ST_EMPTY = 32'h4 | (32'(PAR) << 8);

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [15:0] address;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        tx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .address(address),
    .wd(wd), .rd(rd), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; address = {12'h0, a, 2'b00}; wd = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; we = 1'b0; address = {12'h0, a, 2'b00};
    #1 v = rd;
    sel = 1'b0;
  endtask

  // Push n bytes on consecutive edges with the given divisor and check the
  // whole line waveform, busy flag and STATUS afterwards.
  task automatic run_burst(input string tag, input logic [15:0] div, input logic [7:0] bytes [$]);
    logic        exp_q [$];
    logic [31:0] v;
    int unsigned d, n, acc;
    logic [7:0]  b;
    d   = (div == 0) ? 1 : int'(div);
    n   = bytes.size();
    // First byte goes straight to the shifter, DEPTH more can be buffered.
    acc = (n > DEPTH + 1) ? DEPTH + 1 : n;
    write_reg(2'd2, {16'h0, div});
    if (div != 0) begin
      read_reg(2'd2, v);
      check({tag, "_div"}, v, {16'h0, div});
    end
    exp_q.push_back(1'b1);
    for (int unsigned k = 0; k < acc; k++) begin
      b = bytes[k];
      for (int unsigned c = 0; c < d; c++) exp_q.push_back(1'b0);
      for (int unsigned i = 0; i < 8; i++)
        for (int unsigned c = 0; c < d; c++) exp_q.push_back(b[i]);
      if (PAR != 0)
        for (int unsigned c = 0; c < d; c++) exp_q.push_back(^b);
      for (int unsigned c = 0; c < d; c++) exp_q.push_back(1'b1);
      if (k + 1 < acc) exp_q.push_back(1'b1);
    end
    fork
      begin
        for (int unsigned k = 0; k < n; k++) write_reg(2'd0, {24'h0, bytes[k]});
      end
      begin
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
          @(negedge clk);
          check({tag, "_tx"}, {31'b0, tx}, {31'b0, exp_q[i]});
          check({tag, "_busy"}, {31'b0, tx_busy}, 32'd1);
        end
      end
    join
    @(negedge clk);
    check({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
    check({tag, "_idle_busy"}, {31'b0, tx_busy}, 32'd0);
    read_reg(2'd1, v);
    check({tag, "_status"}, v, ST_EMPTY | ((n > DEPTH + 1) ? 32'h8 : 32'h0));
    write_reg(2'd1, 32'h8);
    read_reg(2'd1, v);
    check({tag, "_status_clr"}, v, ST_EMPTY);
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  bq [$];
    int          zeros;
    reset = 1'b1; sel = 1'b0; we = 1'b0; address = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    read_reg(2'd1, v);
    check("rst_status", v, ST_EMPTY);
    read_reg(2'd2, v);
    check("rst_div", v, 32'd434);

    bq = '{8'hA5};
    run_burst("a5", 16'd4, bq);

    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_burst("ovf", 16'd4, bq);

    bq = '{8'h55, 8'hAA};
    run_burst("b2b", 16'd2, bq);

    bq = '{8'h3C, 8'hC3};
    run_burst("div0", 16'd0, bq);

    for (int it = 0; it < 8; it++) begin
      int unsigned cnt;
      bq = {};
      cnt = $urandom_range(DEPTH + 2, 1);
      for (int unsigned k = 0; k < cnt; k++) bq.push_back(8'($urandom));
      run_burst("rand", 16'($urandom_range(5, 0)), bq);
    end

    // Reset in the middle of a DIVISOR=4 frame
    write_reg(2'd2, 32'd4);
    write_reg(2'd0, 32'hA5);
    repeat (10) @(negedge clk);
    check("mid_tx_low", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_tx", {31'b0, tx}, 32'd1);
    check("mrst_busy", {31'b0, tx_busy}, 32'd0);
    read_reg(2'd1, v);
    check("mrst_status", v, ST_EMPTY);
    read_reg(2'd2, v);
    check("mrst_div", v, 32'd434);
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("mrst_quiet", 32'(zeros), 32'd0);

    // Writes with sel low and to the reserved slot
    sel = 1'b0; we = 1'b1; address = 16'h0000; wd = 32'h77;
    @(posedge clk); #1 we = 1'b0;
    @(negedge clk);
    write_reg(2'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    check("nosel_tx", {31'b0, tx}, 32'd1);
    check("nosel_busy", {31'b0, tx_busy}, 32'd0);
    read_reg(2'd1, v);
    check("nosel_status", v, ST_EMPTY);
    read_reg(2'd3, v);
    check("rsvd_rd", v, 32'd0);
    read_reg(2'd0, v);
    check("data_rd", v, 32'd0);
    read_reg(2'd2, v);
    check("rsvd_div", v, 32'd434);
    sel = 1'b0; address = 16'h0004;
    #1 check("nosel_rd", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter sitting directly downstream of the data-memory MMU on the MMIO region.
- Consumes the same select, write-enable, physical-address and write-data bundle that the MMIO memory bank receives; returns read data into the data-memory read mux.
- Buffers CPU-written bytes in a small FIFO and serialises them 8N1, LSB first, on a tx line at a programmable baud divisor.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the TX FIFO; power of two, minimum 2.
- DIV_RESET, 16'd434, baud divisor loaded at reset (clock cycles per bit).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  MMIO region enable from the MMU; block responds only when high.
- we  input  1  write enable from the CPU store path.
- address  input  16  physical address; only address[3:2] is decoded.
- wd  input  32  write data.
- rd  output  32  read data; combinational from address[3:2], zero when sel is low.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Register map, selected by address[3:2]:
  - 0 DATA: write pushes wd[7:0]; reads 0.
  - 1 STATUS (R): bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count, others 0. STATUS write with wd[3]=1 clears overflow.
  - 2 DIVISOR (R/W): bits[15:0].
  - 3: reads 0, writes ignored.
- Writes take effect on the rising edge where sel & we are both high. Reads are combinational with no wait states.
- Reset: FIFO emptied, overflow=0, DIVISOR=DIV_RESET, FSM=IDLE, tx=1, tx_busy=0, baud counter=0.
- A DIVISOR value of 0 is treated as 1.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - A push while full is dropped and sets overflow.
  - A push and a pop on the same edge while full: the pop frees a slot, the push is accepted, count is unchanged, overflow is not set.
  - A push and a pop on the same edge while empty cannot occur, because a pop requires count>0 before the edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0: pop the head into shift register, load baud counter with DIVISOR-1, go to START.
  - START: tx=0 for DIVISOR cycles.
  - DATA: tx=shift[0]; shift right every DIVISOR cycles; bit index 0..7; after bit 7 go to STOP.
  - STOP: tx=1 for DIVISOR cycles, then IDLE.
  - Each bit boundary reloads the baud counter from the current DIVISOR. A mid-frame DIVISOR write affects only the next bit.
- Latency:
  - DATA write at edge N with FIFO empty and FSM in IDLE: count=1 after edge N; pop at edge N+1; tx=0 from edge N+1.
  - Frame length is 10·DIVISOR cycles.
  - Back-to-back frames have exactly one IDLE cycle (tx=1) between STOP end and the next START.
- tx_busy = (FSM≠IDLE) | (count≠0).
- Reset asserted mid-frame: at the next edge tx=1 and the FIFO is cleared; the partial frame is abandoned.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, driving the even parity of the 8 data bits for DIVISOR cycles.
  - Frame becomes 11·DIVISOR cycles.
  - STATUS bit8 reads 1, indicating parity capability.
- Undefined:
  - No PARITY state; 8N1 only.
  - STATUS bit8 reads 0.

Test Plan:
- Reset, then read STATUS and DIVISOR -> STATUS=0x04 (empty), DIVISOR=434, tx=1, tx_busy=0.
- Write DIVISOR=4, then DATA=0xA5 -> tx sequence (4 cycles each): 0,1,0,1,0,0,1,0,1,1; tx_busy falls after 40 cycles. With UART_TX_PARITY_EN, an extra bit 0 precedes stop.
- DIVISOR=4; write 6 bytes 0x01..0x06 on consecutive cycles -> bytes 0x01..0x05 transmitted (one dequeued immediately, four buffered); 0x06 dropped; STATUS bit3=1. STATUS write wd=0x8 clears it.
- DIVISOR=2; write 0x55 and 0xAA back-to-back -> second start bit begins exactly one idle cycle after the first stop bit ends.
- Reset pulsed at cycle 10 of a DIVISOR=4 frame -> tx=1 the next cycle; STATUS=0x04; no further edges on tx.
- Write with sel=0 to DATA, and address[3:2]=3 with sel=1 -> no FIFO change; rd=0 for both.
